// File: rtl/reg_pkg.sv
// Shared types and default sizing for the WF8 register file with context save/restore.
package reg_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int NUM_REGS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } ctx_state_t;

endpackage

// File: rtl/reg_shadow_bank.sv
// Shadow copy of the register file used for interrupt context save/restore.
// Single port: one write or one (asynchronous) read per cycle at addr.
module reg_shadow_bank
    import reg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [NUM_REGS];

    // Storage update: cleared on reset, otherwise one entry written per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read is combinational so a restore copy lands in the same cycle it is addressed
    assign rdata = mem_r[addr];

endmodule

// File: rtl/register_file_ctx.sv
// WF8 CPU register file: bus write/read ports, accumulator bypass and a
// sequential context save/restore engine that copies one register per cycle.
module register_file_ctx
    import reg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   bus_in,
    output logic [DATA_W-1:0]   bus_out,
    output logic                bus_oe,
    input  logic [NUM_REGS-1:0] write_en,
    input  logic [NUM_REGS-1:0] read_en,
    input  logic [DATA_W-1:0]   acc_in,
    output logic [DATA_W-1:0]   acc_out,
    output logic                rd_conflict,
    input  logic                ctx_save,
    input  logic                ctx_restore,
    output logic                ctx_busy,
    output logic                ctx_done
);

    localparam int               IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int               ACC_IDX  = NUM_REGS - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    ctx_state_t        state_r;
    logic [IDX_W-1:0]  idx_r;
    logic              busy_r;
    logic              done_r;
    logic [DATA_W-1:0] regs_r [NUM_REGS];

    logic              sh_we_s;
    logic [DATA_W-1:0] sh_wdata_s;
    logic [DATA_W-1:0] sh_rdata_s;
    logic [DATA_W-1:0] rd_val_s;
    logic              rd_multi_s;
    logic              rd_one_s;

    assign sh_we_s    = (state_r == SAVE);
    assign sh_wdata_s = regs_r[idx_r];

    reg_shadow_bank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_shadow (
        .clk   (clk),
        .rst   (rst),
        .we    (sh_we_s),
        .addr  (idx_r),
        .wdata (sh_wdata_s),
        .rdata (sh_rdata_s)
    );

    // Context FSM together with register writes; bus writes only land while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (write_en[i]) begin
                            regs_r[i] <= (i == ACC_IDX) ? acc_in : bus_in;
                        end
                    end
                    // Save has priority when both requests arrive together
                    if (ctx_save) begin
                        state_r <= SAVE;
                        idx_r   <= '0;
                        busy_r  <= 1'b1;
                    end else if (ctx_restore) begin
                        state_r <= RESTORE;
                        idx_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                SAVE, RESTORE: begin
                    if (state_r == RESTORE) begin
                        regs_r[idx_r] <= sh_rdata_s;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r <= IDLE;
                        idx_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // One-hot read mux; zero or multiple selects drive nothing onto the bus
    always_comb begin
        rd_val_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_val_s = rd_val_s | (regs_r[i] & {DATA_W{read_en[i]}});
        end
        rd_multi_s  = |(read_en & (read_en - NUM_REGS'(1)));
        rd_one_s    = (read_en != '0) && !rd_multi_s;
        rd_conflict = rd_multi_s;
        if (rd_one_s) begin
            bus_out = rd_val_s;
            bus_oe  = 1'b1;
        end else begin
            bus_out = '0;
            bus_oe  = 1'b0;
        end
    end

    assign acc_out  = regs_r[ACC_IDX];
    assign ctx_busy = busy_r;
    assign ctx_done = done_r;

endmodule
